car_datapath: RTL and testbench

CAR_DATAPATH -- requirements
Module: car_datapath

---
 rtl/car_datapath.sv | 182 ++++++++++++++++++
 tb/tb_car_datapath.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/car_datapath.sv
// Car datapath for the racing game: holds the car position, walks an 8x8 sprite
// into the VGA frame buffer and tracks race completion. Optional sprite ROM: CAR_SPRITE_ROM_EN.
module car_datapath #(
    parameter int unsigned CAR_SIZE   = 8,
    parameter int unsigned START_X    = 76,
    parameter int unsigned START_Y    = 104,
    parameter int unsigned FINISH_Y   = 8,
    parameter int unsigned LANE_MIN_X = 40,
    parameter int unsigned LANE_MAX_X = 112,
    parameter int unsigned STEP_X     = 4,
    parameter int unsigned STEP_Y     = 2,
    parameter logic [2:0]  BG_COLOUR  = 3'b000
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       set_reset_signals,
    input  logic       start_race,
    input  logic       draw_car,
    input  logic       draw_over_car,
    input  logic       move,
    input  logic       forward,
    input  logic       left,
    input  logic       right,
    output logic       DoneDrawCar,
    output logic       DoneDrawOverCar,
    output logic       FinishedRace,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    localparam int unsigned X_W = 8;
    localparam int unsigned Y_W = 7;
    localparam int unsigned PIX_W = 6;
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(CAR_SIZE * CAR_SIZE - 1);

    logic [X_W-1:0]   car_x_q, car_x_d;
    logic [Y_W-1:0]   car_y_q, car_y_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic             done_car_q, done_car_d;
    logic             done_over_q, done_over_d;
    logic             finished_q, finished_d;
    logic [7:0]       vga_x_q, vga_x_d;
    logic [6:0]       vga_y_q, vga_y_d;
    logic [2:0]       vga_colour_q, vga_colour_d;
    logic             vga_plot_q, vga_plot_d;

    logic [2:0]        row_c, col_c;
    logic [2:0]        car_colour_c;
    logic              car_active_c, over_active_c;
    logic signed [9:0] y_next_c, x_left_c;
    logic [9:0]        x_right_c;

    assign row_c = pix_q[5:3];
    assign col_c = pix_q[2:0];

`ifdef CAR_SPRITE_ROM_EN
    // 8x8 sprite, one octal digit per pixel (col 7 leftmost); 0 is transparent.
    function automatic logic [2:0] sprite_rom(input logic [5:0] addr);
        logic [23:0] row_bits;
        case (addr[5:3])
            3'd0:    row_bits = 24'o04444440;
            3'd1:    row_bits = 24'o47444474;
            3'd2:    row_bits = 24'o44111144;
            3'd3:    row_bits = 24'o44444444;
            3'd4:    row_bits = 24'o44444444;
            3'd5:    row_bits = 24'o44111144;
            3'd6:    row_bits = 24'o47444474;
            default: row_bits = 24'o04444440;
        endcase
        return row_bits[3*addr[2:0] +: 3];
    endfunction
    assign car_colour_c = sprite_rom(pix_q);
`else
    assign car_colour_c = 3'b100;
`endif

    // draw_car has precedence; a finished draw stays idle until its done flag clears
    assign car_active_c  = draw_car && !done_car_q;
    assign over_active_c = !draw_car && draw_over_car && !done_over_q;

    // Signed candidates so the finish line and left clamp cannot wrap
    assign y_next_c  = $signed({3'b000, car_y_q}) - $signed(10'(STEP_Y));
    assign x_left_c  = $signed({2'b00, car_x_q}) - $signed(10'(STEP_X));
    assign x_right_c = {2'b00, car_x_q} + 10'(STEP_X);

    always_comb begin
        car_x_d      = car_x_q;
        car_y_d      = car_y_q;
        pix_d        = pix_q;
        done_car_d   = done_car_q;
        done_over_d  = done_over_q;
        finished_d   = finished_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;

        if (draw_over_car) done_car_d = 1'b0;
        if (draw_car)      done_over_d = 1'b0;

        if (start_race || set_reset_signals) begin
            car_x_d     = X_W'(START_X);
            car_y_d     = Y_W'(START_Y);
            finished_d  = 1'b0;
            pix_d       = '0;
            done_car_d  = 1'b0;
            done_over_d = 1'b0;
        end else begin
            if (car_active_c || over_active_c) begin
                vga_x_d      = car_x_q + 8'(col_c);
                vga_y_d      = car_y_q + 7'(row_c);
                vga_plot_d   = 1'b1;
                vga_colour_d = car_active_c ? car_colour_c : BG_COLOUR;
`ifdef CAR_SPRITE_ROM_EN
                if (car_active_c && (car_colour_c == 3'b000)) vga_plot_d = 1'b0;
`endif
                if (pix_q == PIX_LAST) begin
                    pix_d = '0;
                    if (car_active_c) done_car_d = 1'b1;
                    else              done_over_d = 1'b1;
                end else begin
                    pix_d = pix_q + PIX_W'(1);
                end
            end

            // Position only moves between sprite passes
            if (move && !finished_q && (pix_q == '0)) begin
                if (forward) begin
                    if (y_next_c <= $signed(10'(FINISH_Y))) begin
                        car_y_d    = Y_W'(FINISH_Y);
                        finished_d = 1'b1;
                    end else begin
                        car_y_d = Y_W'(y_next_c);
                    end
                end else if (left && !right) begin
                    if (x_left_c < $signed(10'(LANE_MIN_X))) car_x_d = X_W'(LANE_MIN_X);
                    else                                     car_x_d = X_W'(x_left_c);
                end else if (right && !left) begin
                    if (x_right_c > 10'(LANE_MAX_X)) car_x_d = X_W'(LANE_MAX_X);
                    else                             car_x_d = X_W'(x_right_c);
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            car_x_q      <= X_W'(START_X);
            car_y_q      <= Y_W'(START_Y);
            pix_q        <= '0;
            done_car_q   <= 1'b0;
            done_over_q  <= 1'b0;
            finished_q   <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            car_x_q      <= car_x_d;
            car_y_q      <= car_y_d;
            pix_q        <= pix_d;
            done_car_q   <= done_car_d;
            done_over_q  <= done_over_d;
            finished_q   <= finished_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

    assign DoneDrawCar     = done_car_q;
    assign DoneDrawOverCar = done_over_q;
    assign FinishedRace    = finished_q;
    assign vga_x           = vga_x_q;
    assign vga_y           = vga_y_q;
    assign vga_colour      = vga_colour_q;
    assign vga_plot        = vga_plot_q;

endmodule

// File: tb/tb_car_datapath.sv
// Bench for car_datapath: directed and random moves checked by redrawing the car
// against a plain-arithmetic position model.
module tb_car_datapath;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       set_reset_signals, start_race, draw_car, draw_over_car;
    logic       move, forward, left, right;
    logic       DoneDrawCar, DoneDrawOverCar, FinishedRace;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    int tests = 0;
    int fails = 0;
    int mx, my;
    bit mfin;
    bit next_over;

    always #5 Clock = ~Clock;

    car_datapath dut (
        .Clock(Clock), .Resetn(Resetn),
        .set_reset_signals(set_reset_signals), .start_race(start_race),
        .draw_car(draw_car), .draw_over_car(draw_over_car), .move(move),
        .forward(forward), .left(left), .right(right),
        .DoneDrawCar(DoneDrawCar), .DoneDrawOverCar(DoneDrawOverCar),
        .FinishedRace(FinishedRace), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Hold one draw command for 65 cycles and check all 64 pixels plus done timing
    task automatic draw(input bit over);
        if (over) draw_over_car = 1'b1;
        else      draw_car = 1'b1;
        for (int k = 1; k <= 65; k++) begin
            step();
            if (k <= 64) begin
                int p;
                p = k - 1;
                chk("pix_x", 32'(vga_x), 32'(mx + p % 8));
                chk("pix_y", 32'(vga_y), 32'(my + p / 8));
                if (over) begin
                    chk("over_plot", 32'(vga_plot), 32'd1);
                    chk("over_colour", 32'(vga_colour), 32'd0);
                end else begin
`ifdef CAR_SPRITE_ROM_EN
                    chk("car_plot_opaque", 32'(vga_plot), 32'(vga_colour != 3'b000));
                    if (p == 0) chk("car_transparent_px0", 32'(vga_plot), 32'd0);
`else
                    chk("car_plot", 32'(vga_plot), 32'd1);
                    chk("car_colour", 32'(vga_colour), 32'd4);
`endif
                end
            end else begin
                chk("plot_idle_after_done", 32'(vga_plot), 32'd0);
            end
            if (k == 1) chk("other_done_cleared", 32'(over ? DoneDrawCar : DoneDrawOverCar), 32'd0);
            chk(over ? "done_over" : "done_car",
                32'(over ? DoneDrawOverCar : DoneDrawCar), 32'(k >= 64));
        end
        draw_car = 1'b0;
        draw_over_car = 1'b0;
    endtask

    task automatic check_pos();
        draw(next_over);
        next_over = !next_over;
    endtask

    task automatic do_move(input bit f, input bit l, input bit r);
        move = 1'b1; forward = f; left = l; right = r;
        step();
        move = 1'b0; forward = 1'b0; left = 1'b0; right = 1'b0;
        if (!mfin) begin
            if (f) begin
                if (my - 2 <= 8) begin
                    my = 8;
                    mfin = 1'b1;
                end else begin
                    my = my - 2;
                end
            end else if (l && !r) begin
                mx = (mx - 4 < 40) ? 40 : mx - 4;
            end else if (r && !l) begin
                mx = (mx + 4 > 112) ? 112 : mx + 4;
            end
        end
        chk("finished", 32'(FinishedRace), 32'(mfin));
    endtask

    task automatic restart(input bit use_start);
        if (use_start) start_race = 1'b1;
        else           set_reset_signals = 1'b1;
        step();
        start_race = 1'b0;
        set_reset_signals = 1'b0;
        mx = 76; my = 104; mfin = 1'b0;
        chk("restart_finished", 32'(FinishedRace), 32'd0);
        chk("restart_done_car", 32'(DoneDrawCar), 32'd0);
    endtask

    initial begin
        Resetn = 1'b0;
        {set_reset_signals, start_race, draw_car, draw_over_car} = '0;
        {move, forward, left, right} = '0;
        next_over = 1'b0;
        step();
        step();
        chk("rst_vga_x", 32'(vga_x), 32'd0);
        chk("rst_vga_y", 32'(vga_y), 32'd0);
        chk("rst_colour", 32'(vga_colour), 32'd0);
        chk("rst_plot", 32'(vga_plot), 32'd0);
        chk("rst_done_car", 32'(DoneDrawCar), 32'd0);
        chk("rst_done_over", 32'(DoneDrawOverCar), 32'd0);
        chk("rst_finished", 32'(FinishedRace), 32'd0);
        Resetn = 1'b1;

        // Start, draw car, then erase it
        restart(1'b1);
        check_pos();
        check_pos();

        // Left clamp at the lane edge
        for (int i = 0; i < 8; i++) do_move(1'b0, 1'b1, 1'b0);
        check_pos();
        do_move(1'b0, 1'b1, 1'b0);
        check_pos();
        do_move(1'b0, 1'b1, 1'b0);
        check_pos();

        // Right clamp, then conflicting directions
        for (int i = 0; i < 17; i++) do_move(1'b0, 1'b0, 1'b1);
        check_pos();
        do_move(1'b0, 1'b0, 1'b1);
        check_pos();
        do_move(1'b0, 1'b0, 1'b1);
        check_pos();
        do_move(1'b0, 1'b1, 1'b1);
        check_pos();
        do_move(1'b0, 1'b0, 1'b0);
        check_pos();

        // Random moves against the model
        for (int i = 0; i < 36; i++) begin
            int d;
            d = int'($urandom_range(0, 4));
            do_move(d == 0, d == 1 || d == 3, d == 2 || d == 3);
            if (i % 6 == 5) check_pos();
        end

        // Finish line approach, overshoot clamp and lockout
        restart(1'b0);
        for (int i = 0; i < 47; i++) do_move(1'b1, 1'b0, 1'b0);
        check_pos();
        do_move(1'b1, 1'b0, 1'b0);
        chk("finish_flag", 32'(FinishedRace), 32'd1);
        check_pos();
        do_move(1'b1, 1'b0, 1'b0);
        do_move(1'b0, 1'b1, 1'b0);
        check_pos();
        restart(1'b0);
        check_pos();

        // Reset in the middle of a car draw
        restart(1'b0);
        draw_car = 1'b1;
        for (int i = 0; i < 30; i++) step();
        chk("middraw_plot", 32'(vga_plot), 32'd1);
        Resetn = 1'b0;
        step();
        Resetn = 1'b1;
        draw_car = 1'b0;
        chk("midrst_plot", 32'(vga_plot), 32'd0);
        chk("midrst_done_car", 32'(DoneDrawCar), 32'd0);
        chk("midrst_vga_x", 32'(vga_x), 32'd0);
        mx = 76; my = 104; mfin = 1'b0;
        draw(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
